// File: rtl/x68k_ldr_pkg.sv
// Shared types for the X68K loader write sequencer: FSM states and FIFO entry layout.
package x68k_ldr_pkg;
  localparam int LDR_ADDR_W = 20;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, DONE} ldr_state_t;

  typedef struct packed {
    logic [LDR_ADDR_W-1:0] addr;
    logic [7:0]            data;
  } ldr_entry_t;
endpackage

// File: rtl/x68k_ldr_fifo.sv
// Small synchronous FIFO of loader entries; pushes to a full FIFO and pops of an empty one are ignored.
module x68k_ldr_fifo
  import x68k_ldr_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  ldr_entry_t i_din,
  input  logic       i_pop,
  output ldr_entry_t o_head,
  output logic       o_full,
  output logic       o_empty,
  output logic [PW:0] o_count
);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  ldr_entry_t       r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [PW:0]      r_count;
  logic             w_push, w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/x68k_ldr_write_seq.sv
// Buffers HPS ioctl download bytes and replays them one at a time into the X68K loader port,
// handshaking on the rising edge of ldr_ack and flagging completion, timeouts and overflow.
module x68k_ldr_write_seq
  import x68k_ldr_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = LDR_ADDR_W,  // must match the entry struct width
  parameter int ACK_TIMEOUT = 4096
) (
  input  logic              i_clk_sys,
  input  logic              i_reset,
  input  logic              i_ioctl_download,
  input  logic              i_ioctl_wr,
  input  logic [ADDR_W-1:0] i_ioctl_addr,
  input  logic [7:0]        i_ioctl_dout,
  output logic              o_ioctl_wait,
  output logic [ADDR_W-1:0] o_ldr_addr,
  output logic [7:0]        o_ldr_wdat,
  output logic              o_ldr_aen,
  output logic              o_ldr_wr,
  input  logic              i_ldr_ack,
  output logic              o_ldr_done,
  output logic              o_err_timeout,
  output logic              o_err_overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam logic [PW:0]   WAIT_LVL = (PW+1)'(DEPTH-1);
  localparam logic [TW-1:0] TMR_MAX  = TW'(ACK_TIMEOUT-1);

  ldr_state_t    r_state, w_state_n;
  logic          r_ack_q, r_dl_q, r_seen;
  logic [TW-1:0] r_timer;
  logic          w_ack_rise, w_push_req, w_pop, w_full, w_empty;
  logic [PW:0]   w_count, w_cnt_n;
  ldr_entry_t    w_head, w_din;

  assign w_ack_rise = i_ldr_ack & ~r_ack_q;
  assign w_push_req = i_ioctl_wr & i_ioctl_download & ~o_ldr_done;
  assign w_pop      = (r_state == ISSUE);
  assign w_din      = '{addr: i_ioctl_addr, data: i_ioctl_dout};

  x68k_ldr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk_sys),
    .i_rst   (i_reset),
    .i_push  (w_push_req),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Occupancy after this cycle's push/pop, used to raise the throttle one entry early.
  always_comb begin
    w_cnt_n = w_count;
    if (w_push_req && !w_full) w_cnt_n = w_cnt_n + 1'b1;
    if (w_pop && !w_empty)     w_cnt_n = w_cnt_n - 1'b1;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:  if (!w_empty)                          w_state_n = ISSUE;
             else if (r_seen && !i_ioctl_download)  w_state_n = DONE;
      ISSUE: w_state_n = WAIT;
      WAIT:  if (w_ack_rise || r_timer == TMR_MAX)  w_state_n = GAP;
      GAP:   if (!w_empty)                          w_state_n = ISSUE;
             else if (r_seen && !i_ioctl_download)  w_state_n = DONE;
             else                                   w_state_n = IDLE;
      DONE:  w_state_n = DONE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_ack_q        <= 1'b0;
      r_dl_q         <= 1'b0;
      r_seen         <= 1'b0;
      r_timer        <= '0;
      o_ldr_wr       <= 1'b0;
      o_ldr_addr     <= '0;
      o_ldr_wdat     <= '0;
      o_ldr_done     <= 1'b0;
      o_ldr_aen      <= 1'b0;
      o_ioctl_wait   <= 1'b0;
      o_err_timeout  <= 1'b0;
      o_err_overflow <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_ack_q      <= i_ldr_ack;
      r_dl_q       <= i_ioctl_download;
      r_seen       <= r_seen | (i_ioctl_download & ~r_dl_q);
      o_ldr_done   <= (w_state_n == DONE);
      o_ldr_aen    <= (i_ioctl_download | (r_state != IDLE) | ~w_empty) & (w_state_n != DONE);
      o_ioctl_wait <= (w_cnt_n >= WAIT_LVL) & (w_state_n != DONE);
      if (w_push_req && w_full) o_err_overflow <= 1'b1;
      case (r_state)
        ISSUE: begin
          o_ldr_addr <= w_head.addr;
          o_ldr_wdat <= w_head.data;
          o_ldr_wr   <= 1'b1;
          r_timer    <= '0;
        end
        WAIT: begin
          if (w_state_n == GAP) begin
            o_ldr_wr <= 1'b0;
            if (!w_ack_rise) o_err_timeout <= 1'b1;
          end else if (r_timer != '1) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_x68k_ldr_write_seq.sv
// Self-checking bench for x68k_ldr_write_seq: table-driven downloads plus corner-case sequences,
// with a scoreboard of expected loader writes popped whenever ldr_wr rises.
module tb_x68k_ldr_write_seq;
  localparam int AW = 20;

  logic          clk = 1'b0, rst = 1'b1, dl = 1'b0, wr = 1'b0, ack = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [7:0]    dout = '0;
  logic          o_wait, o_aen, o_wr, o_done, o_eto, o_eov;
  logic [AW-1:0] o_addr;
  logic [7:0]    o_wdat;

  x68k_ldr_write_seq #(.DEPTH(4), .ADDR_W(AW), .ACK_TIMEOUT(4096)) dut (
    .i_clk_sys(clk), .i_reset(rst), .i_ioctl_download(dl), .i_ioctl_wr(wr),
    .i_ioctl_addr(addr), .i_ioctl_dout(dout), .o_ioctl_wait(o_wait),
    .o_ldr_addr(o_addr), .o_ldr_wdat(o_wdat), .o_ldr_aen(o_aen), .o_ldr_wr(o_wr),
    .i_ldr_ack(ack), .o_ldr_done(o_done), .o_err_timeout(o_eto), .o_err_overflow(o_eov)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [27:0] sb_q[$];
  int  ack_dly = 1;           // 0 = never acknowledge
  bit  ack_force = 0, ack_val = 0;
  int  exp_len = 0;           // expected ldr_wr high time in cycles, 0 = don't check
  bit  saw_wait = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Core-side responder: raise ack ack_dly cycles into a write, drop it once ldr_wr falls.
  initial begin : resp
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (ack_force) ack = ack_val;
      else if (o_wr) begin
        cnt++;
        if (ack_dly > 0 && cnt >= ack_dly) ack = 1'b1;
      end else begin
        cnt = 0;
        ack = 1'b0;
      end
    end
  end

  // Monitor: each ldr_wr rise must match the scoreboard head; addr/data stable while high.
  initial begin : mon
    bit prev;
    int len;
    logic [AW-1:0] ca;
    logic [7:0] cd;
    logic [27:0] e;
    prev = 0; len = 0; ca = '0; cd = '0;
    forever begin
      @(negedge clk);
      if (o_wr && !prev) begin
        ca = o_addr; cd = o_wdat; len = 1;
        if (sb_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_wr: addr %0h data %0h with empty scoreboard", o_addr, o_wdat);
        end else begin
          e = sb_q.pop_front();
          chk("ldr_addr", o_addr, e[27:8]);
          chk("ldr_wdat", o_wdat, e[7:0]);
        end
      end else if (o_wr) begin
        len++;
        if (o_addr !== ca || o_wdat !== cd) chk("wr_stable", {o_addr, o_wdat}, {ca, cd});
      end else if (prev && exp_len > 0) begin
        chk("wr_len", len, exp_len);
      end
      prev = o_wr;
    end
  end

  task automatic do_reset();
    rst = 1'b1; dl = 1'b0; wr = 1'b0; ack_force = 0; exp_len = 0;
    sb_q.delete();
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [7:0] d, input bit honor, input bit exp);
    int k;
    k = 0;
    while (honor && o_wait && k < 200) begin saw_wait = 1; tick(1); k++; end
    if (k >= 200) chk("wait_release", o_wait, 0);
    wr = 1'b1; addr = a; dout = d;
    if (exp) sb_q.push_back({a, d});
    tick(1);
    wr = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!o_done && k < budget) begin tick(1); k++; end
    chk("ldr_done", o_done, 1);
  endtask

  task automatic wait_wr(input int budget);
    int k;
    k = 0;
    while (!o_wr && k < budget) begin tick(1); k++; end
    chk("wr_seen", o_wr, 1);
  endtask

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
    int            dly;
    int            len;
    bit            to;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{20'h00000, 8'hA5, 3, 3,    1'b0};
    tbl[1] = '{20'h12345, 8'h3C, 1, 1,    1'b0};
    tbl[2] = '{20'hFFFFE, 8'hFF, 6, 6,    1'b0};
    tbl[3] = '{20'h00100, 8'h00, 0, 4096, 1'b1};

    #2;
    chk("rst_wr", o_wr, 0);     chk("rst_done", o_done, 0); chk("rst_aen", o_aen, 0);
    chk("rst_wait", o_wait, 0); chk("rst_eto", o_eto, 0);   chk("rst_eov", o_eov, 0);
    chk("rst_addr", o_addr, 0); chk("rst_wdat", o_wdat, 0);

    // Two-byte downloads with varying ack latency; the last record never acks.
    for (int i = 0; i < 4; i++) begin
      do_reset();
      ack_dly = tbl[i].dly; exp_len = tbl[i].len;
      dl = 1'b1;
      tick(2);
      chk("aen_dl", o_aen, 1);
      send(tbl[i].a, tbl[i].d, 1, 1);
      send(tbl[i].a + 1'b1, ~tbl[i].d, 1, 1);
      dl = 1'b0;
      wait_done(10000);
      chk("done_aen", o_aen, 0);
      chk("done_wait", o_wait, 0);
      chk("done_eto", o_eto, tbl[i].to);
      chk("done_eov", o_eov, 0);
      chk("all_written", sb_q.size(), 0);
      dl = 1'b1;
      send(20'h00055, 8'h77, 1, 0);
      tick(10);
      chk("done_sticky", o_done, 1);
      chk("done_ign_eov", o_eov, 0);
      chk("done_ign_wait", o_wait, 0);
      dl = 1'b0;
    end

    // 16-byte burst honouring the throttle.
    do_reset();
    ack_dly = 1; exp_len = 1; saw_wait = 0;
    dl = 1'b1;
    tick(1);
    for (int i = 0; i < 16; i++) send(AW'(i), 8'h10 + 8'(i), 1, 1);
    dl = 1'b0;
    wait_done(500);
    chk("burst_saw_wait", saw_wait, 1);
    chk("burst_eov", o_eov, 0);
    chk("burst_written", sb_q.size(), 0);

    // Overflow: one byte in flight plus four buffered; the sixth is dropped.
    do_reset();
    ack_dly = 0; exp_len = 0;
    dl = 1'b1;
    tick(1);
    for (int i = 0; i < 5; i++) send(20'h00200 + AW'(i), 8'hC0 + 8'(i), 0, 1);
    chk("ovf_before", o_eov, 0);
    chk("ovf_wait", o_wait, 1);
    send(20'h00205, 8'hC5, 0, 0);
    chk("ovf_flag", o_eov, 1);
    ack_dly = 2;
    dl = 1'b0;
    wait_done(1000);
    chk("ovf_written", sb_q.size(), 0);
    chk("ovf_eto", o_eto, 0);

    // Reset while a write is waiting for ack.
    do_reset();
    ack_dly = 0; exp_len = 0;
    dl = 1'b1;
    tick(1);
    send(20'h00300, 8'h11, 1, 1);
    send(20'h00301, 8'h22, 1, 1);
    wait_wr(20);
    tick(3);
    #2 rst = 1'b1;
    #1;
    chk("rstw_wr", o_wr, 0);
    chk("rstw_done", o_done, 0);
    chk("rstw_aen", o_aen, 0);
    sb_q.delete();
    tick(2);
    rst = 1'b0;
    tick(5);
    chk("rstw_empty", o_wr, 0);
    chk("rstw_eto", o_eto, 0);
    ack_dly = 2; exp_len = 2;
    send(20'hABCDE, 8'h5A, 1, 1);
    dl = 1'b0;
    wait_done(100);
    chk("rstw_written", sb_q.size(), 0);

    // ack already high before the write: only a fresh rising edge completes it.
    do_reset();
    ack_force = 1; ack_val = 1; exp_len = 0;
    tick(2);
    dl = 1'b1;
    send(20'h00042, 8'h99, 1, 1);
    wait_wr(20);
    tick(10);
    chk("stuck_hold", o_wr, 1);
    ack_val = 0;
    tick(3);
    chk("stuck_low_hold", o_wr, 1);
    ack_val = 1;
    tick(3);
    chk("stuck_complete", o_wr, 0);
    chk("stuck_eto", o_eto, 0);
    ack_force = 0;
    dl = 1'b0;
    wait_done(50);
    chk("stuck_written", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL global_timeout: simulation exceeded cycle budget");
    $fatal(1, "timeout");
  end
endmodule
